// File: rtl/daisy_duty_gen.sv
// rtl/daisy_duty_gen.sv - programmable period/high-time rectangular waveform generator
// Configuration loads are staged and only take effect at period boundaries.
module daisy_duty_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] period_in,
  input  logic [CNT_W-1:0] high_in,
  output logic             out,
  output logic             cyc_start,
  output logic             pending,
  output logic             err
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] per, per_n;
  logic [CNT_W-1:0] hi, hi_n;
  logic [CNT_W-1:0] pper, pper_n;
  logic [CNT_W-1:0] phi, phi_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pending_n;
  logic             out_n;
  logic             cyc_start_n;
  logic             err_n;

  logic             load_ok;
  logic [CNT_W-1:0] load_hi;
  logic [CNT_W-1:0] cfg_per;
  logic [CNT_W-1:0] cfg_hi;
  logic             cfg_pend;
  logic             apply;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      per       <= CNT_W'(2);
      hi        <= CNT_W'(1);
      pper      <= CNT_W'(2);
      phi       <= CNT_W'(1);
      cnt       <= '0;
      pending   <= 1'b0;
      out       <= 1'b0;
      cyc_start <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      per       <= per_n;
      hi        <= hi_n;
      pper      <= pper_n;
      phi       <= phi_n;
      cnt       <= cnt_n;
      pending   <= pending_n;
      out       <= out_n;
      cyc_start <= cyc_start_n;
      err       <= err_n;
    end
  end

  // A legal load in the same cycle as a period start is folded into the staged config.
  always_comb begin
    load_ok  = load && (period_in >= CNT_W'(2));
    load_hi  = (high_in > period_in) ? period_in : high_in;
    cfg_per  = load_ok ? period_in : pper;
    cfg_hi   = load_ok ? load_hi : phi;
    cfg_pend = load_ok || pending;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    per_n     = per;
    hi_n      = hi;
    pper_n    = cfg_per;
    phi_n     = cfg_hi;
    pending_n = cfg_pend;
    apply     = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (en) begin
          state_n = RUN;
          apply   = 1'b1;
        end
      end
      RUN: begin
        if (cnt == per - CNT_W'(1)) begin
          cnt_n = '0;
          if (en) begin
            apply = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (apply && cfg_pend) begin
      per_n     = cfg_per;
      hi_n      = cfg_hi;
      pending_n = 1'b0;
    end

    // Outputs are registered from next-state values so they line up with cnt.
    out_n       = (state_n == RUN) && (cnt_n < hi_n);
    cyc_start_n = (state_n == RUN) && apply;
    err_n       = load && !load_ok;
  end

endmodule

// File: tb/tb_daisy_duty_gen.sv
// tb/tb_daisy_duty_gen.sv - randomized self-checking bench for daisy_duty_gen
// Reference model walks the waveform rules period by period with plain integers.
module tb_daisy_duty_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] period_in;
  logic [7:0] high_in;
  logic       out;
  logic       cyc_start;
  logic       pending;
  logic       err;

  int checks   = 0;
  int failures = 0;

  bit m_run;
  int m_pos;
  int m_per, m_hi, m_pper, m_phi;
  bit m_pend, m_out, m_cs, m_err;

  daisy_duty_gen #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .period_in (period_in),
    .high_in   (high_in),
    .out       (out),
    .cyc_start (cyc_start),
    .pending   (pending),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_pos  = 0;
    m_per  = 2;
    m_hi   = 1;
    m_pper = 2;
    m_phi  = 1;
    m_pend = 0;
    m_out  = 0;
    m_cs   = 0;
    m_err  = 0;
  endtask

  task automatic model_step(input bit e, input bit l, input int p, input int h);
    bit start;
    start = 0;
    m_err = l && (p < 2);
    if (l && p >= 2) begin
      m_pper = p;
      m_phi  = (h < p) ? h : p;
      m_pend = 1;
    end
    if (!m_run) begin
      if (e) begin
        m_run = 1;
        m_pos = 0;
        start = 1;
      end
    end else if (m_pos == m_per - 1) begin
      m_pos = 0;
      if (e) start = 1;
      else   m_run = 0;
    end else begin
      m_pos++;
    end
    if (start && m_pend) begin
      m_per  = m_pper;
      m_hi   = m_phi;
      m_pend = 0;
    end
    m_cs  = start;
    m_out = m_run && (m_pos < m_hi);
  endtask

  // Called at a falling edge; drives inputs, advances one clock, checks at the next falling edge.
  task automatic cycle(input bit e, input bit l, input int p, input int h);
    en        = e;
    load      = l;
    period_in = 8'(p);
    high_in   = 8'(h);
    @(posedge clk);
    model_step(e, l, p, h);
    @(negedge clk);
    check("out", out, int'(m_out));
    check("cyc_start", cyc_start, int'(m_cs));
    check("pending", pending, int'(m_pend));
    check("err", err, int'(m_err));
  endtask

  task automatic run_count(input int n, input bit e, output int highs, output int starts);
    highs  = 0;
    starts = 0;
    for (int i = 0; i < n; i++) begin
      cycle(e, 0, 0, 0);
      highs  += int'(out);
      starts += int'(cyc_start);
    end
  endtask

  initial begin
    int  hs, ss;
    bit  found;
    int  p, h;

    rst = 1'b1; en = 1'b0; load = 1'b0; period_in = '0; high_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out", out, 0);
    check("rst_cyc_start", cyc_start, 0);
    check("rst_pending", pending, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    run_count(20, 1, hs, ss);
    check("default_highs", hs, 10);
    check("default_starts", ss, 10);

    run_count(3, 0, hs, ss);
    cycle(0, 1, 10, 3);
    check("idle_load_pending", pending, 1);
    run_count(20, 1, hs, ss);
    check("p10h3_highs", hs, 6);
    check("p10h3_starts", ss, 2);

    cycle(1, 1, 8, 6);
    run_count(8, 1, hs, ss);
    check("boundary_load_highs", hs, 6);
    check("boundary_load_starts", ss, 1);

    run_count(3, 1, hs, ss);
    cycle(1, 1, 10, 3);
    run_count(3, 1, hs, ss);
    run_count(10, 1, hs, ss);
    check("midload_highs", hs, 3);
    check("midload_starts", ss, 1);

    cycle(1, 1, 5, 0);
    run_count(10, 1, hs, ss);
    run_count(10, 1, hs, ss);
    check("hi0_highs", hs, 0);
    check("hi0_starts", ss, 2);
    cycle(1, 1, 5, 255);
    run_count(10, 1, hs, ss);
    run_count(10, 1, hs, ss);
    check("hiclamp_highs", hs, 10);
    check("hiclamp_starts", ss, 2);

    cycle(1, 1, 1, 0);
    check("err_pulse", err, 1);
    check("err_pending", pending, 0);
    cycle(1, 0, 0, 0);
    check("err_clear", err, 0);

    cycle(1, 1, 10, 3);
    found = cyc_start && !pending;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(1, 0, 0, 0);
      found = cyc_start && !pending;
    end
    check("align_found", found, 1);
    run_count(2, 1, hs, ss);
    run_count(7, 0, hs, ss);
    check("drain_highs", hs, 0);
    check("drain_starts", ss, 0);
    run_count(5, 0, hs, ss);
    check("stopped_starts", ss, 0);

    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1, 0, 0, 0);
      found = out;
    end
    check("high_phase_found", found, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_pending", pending, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_count(10, 1, hs, ss);
    check("restart_highs", hs, 5);
    check("restart_starts", ss, 5);

    for (int i = 0; i < 3000; i++) begin
      p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 255));
      h = ($urandom_range(0, 3) == 0) ? p : int'($urandom_range(0, 255));
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, p, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
